// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int unsigned INSTR_LEN  = 32;
    localparam int unsigned OPCODE_LEN = 6;
    localparam int unsigned FUNCT_LEN  = 6;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [31:0]          pc;
        logic [INSTR_LEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [OPCODE_LEN-1:0] opcode_of(input logic [INSTR_LEN-1:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [FUNCT_LEN-1:0] funct_of(input logic [INSTR_LEN-1:0] instr);
        return instr[5:0];
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, occupancy count and async active-low reset.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count < CW'(DEPTH));
    assign pop_ok  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage is not reset; consumers gate the head with count.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: credit-limited fetch unit with redirect flush and in-order decode buffer.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_EXC_EN.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [31:0]           imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSTR_LEN-1:0]  imem_rsp_data,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INSTR_LEN-1:0]  id_instr,
    output logic [31:0]           id_pc,
    output logic [OPCODE_LEN-1:0] id_opcode,
    output logic [FUNCT_LEN-1:0]  id_funct,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  fetch_exc
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]    pc;
    logic [CW-1:0]  inflight;
    logic [CW-1:0]  drop;
    logic           running;
    logic           exc_q;
    logic [CW:0]    credit_used;
    logic           req_fire;
    logic           rsp_fire;
    logic           buf_push;
    logic           id_fire;
    logic [31:0]    pend_pc;
    logic [CW-1:0]  pend_count_unused;
    logic [CW-1:0]  buf_count;
    fetch_entry_t   buf_head;
    logic [31:0]    target_pc;

    assign credit_used    = {1'b0, inflight} + {1'b0, buf_count};
    assign imem_req_valid = running && !redirect_valid && !exc_q && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_fire       = imem_rsp_valid && (inflight != '0);
    assign buf_push       = rsp_fire && (drop == '0) && !redirect_valid;
    assign id_valid       = (buf_count != '0);
    assign id_fire        = id_valid && id_ready;

    assign id_instr  = id_valid ? buf_head.instr : '0;
    assign id_pc     = id_valid ? buf_head.pc : '0;
    assign id_opcode = opcode_of(id_instr);
    assign id_funct  = funct_of(id_instr);

    fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (pc),
        .pop       (buf_push),
        .head      (pend_pc),
        .count     (pend_count_unused)
    );

    fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data ({pend_pc, imem_rsp_data}),
        .pop       (id_fire),
        .head      (buf_head),
        .count     (buf_count)
    );

`ifdef IFU_MISALIGN_EXC_EN
    assign target_pc = redirect_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q <= 1'b0;
        end else if (redirect_valid) begin
            exc_q <= |redirect_pc[1:0];
        end
    end
`else
    assign target_pc = {redirect_pc[31:2], 2'b00};
    assign exc_q     = 1'b0;
`endif

    assign fetch_exc = exc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            running  <= 1'b0;
        end else begin
            running  <= 1'b1;
            inflight <= inflight + CW'(req_fire) - CW'(rsp_fire);
            // No request can fire during a redirect, so every outstanding
            // fetch left after this cycle's response is stale.
            if (redirect_valid) begin
                pc   <= target_pc;
                drop <= inflight - CW'(rsp_fire);
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (rsp_fire && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed scoreboard bench for instr_fetch: memory model returns addr ^ 32'hA5A5_0000.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_exc;

    instr_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode),
        .id_funct       (id_funct),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_exc      (fetch_exc)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned n_req = 0;
    int unsigned n_pop = 0;
    logic [31:0] memq[$];
    logic [63:0] sbq[$];
    logic [31:0] exp_addr;
    logic        watch;
    logic [31:0] first_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluates the handshakes the coming rising edge will see.
    task automatic observe();
        logic [63:0] e;
        if (id_valid && id_ready) begin
            n_pop++;
            if (watch) begin
                first_pc = id_pc;
                watch    = 1'b0;
            end
            if (sbq.size() == 0) begin
                chk("id_unexpected", id_valid, 0);
            end else begin
                e = sbq.pop_front();
                chk("id_pc", id_pc, e[63:32]);
                chk("id_instr", id_instr, e[31:0]);
                chk("id_opcode", id_opcode, e[31:26]);
                chk("id_funct", id_funct, e[5:0]);
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_addr, exp_addr);
            memq.push_back(exp_addr);
            sbq.push_back({exp_addr, exp_addr ^ KEY});
            exp_addr = exp_addr + 32'd4;
            n_req++;
        end
        if (redirect_valid) begin
            chk("req_during_redirect", imem_req_valid, 0);
            sbq.delete();
`ifdef IFU_MISALIGN_EXC_EN
            exp_addr = redirect_pc;
`else
            exp_addr = {redirect_pc[31:2], 2'b00};
`endif
        end
    endtask

    task automatic step(input logic rdy, input logic hold, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        id_ready       = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (!hold && memq.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq.pop_front() ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        observe();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_instr", id_instr, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_fetch_exc", fetch_exc, 0);
        memq.delete();
        sbq.delete();
        exp_addr = RST_PC;
        watch    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_req_idle", imem_req_valid, 0);
    endtask

    initial begin
        int unsigned n0;
        int unsigned p0;
        imem_req_ready = 1'b1;
        first_pc       = '1;

        // Reset, then streaming with a mid-stream reset
        do_reset();
        step(1, 0, 0, '0);
        chk("first_req_valid", imem_req_valid, 1);
        repeat (20) step(1, 0, 0, '0);
        chk("stream_progress", n_pop >= 8, 1);
        do_reset();
        repeat (6) step(1, 0, 0, '0);

        // Back-pressure from empty
        do_reset();
        n0 = n_req;
        repeat (10) step(0, 0, 0, '0);
        chk("bp_req_count", n_req - n0, DEPTH);
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_id_valid", id_valid, 1);
        p0 = n_pop;
        repeat (12) step(1, 0, 0, '0);
        chk("bp_release_pops", n_pop - p0 >= 4, 1);

        // Redirect with two fetches in flight
        do_reset();
        n0 = n_req;
        repeat (3) step(1, 1, 0, '0);
        chk("two_inflight", n_req - n0, 2);
        step(1, 0, 1, 32'h0000_4000);
        watch = 1'b1;
        repeat (10) step(1, 0, 0, '0);
        chk("redir_first_pc", first_pc, 32'h0000_4000);

        // Redirect + decode pop + response in the same cycle
        do_reset();
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        step(0, 1, 0, '0);
        p0 = n_pop;
        step(1, 0, 1, 32'h0000_5000);
        chk("same_cycle_pops", n_pop - p0, 1);
        watch = 1'b1;
        repeat (10) step(1, 0, 0, '0);
        chk("same_cycle_next_pc", first_pc, 32'h0000_5000);

        // Misaligned redirect
        step(1, 0, 1, 32'h0000_4002);
`ifdef IFU_MISALIGN_EXC_EN
        repeat (4) begin
            step(1, 0, 0, '0);
            chk("exc_set", fetch_exc, 1);
            chk("exc_no_req", imem_req_valid, 0);
        end
        step(1, 0, 1, 32'h0000_4010);
        step(1, 0, 0, '0);
        chk("exc_clear", fetch_exc, 0);
        watch = 1'b1;
        repeat (8) step(1, 0, 0, '0);
        chk("exc_resume_pc", first_pc, 32'h0000_4010);
`else
        step(1, 0, 0, '0);
        chk("misalign_no_exc", fetch_exc, 0);
        watch = 1'b1;
        repeat (8) step(1, 0, 0, '0);
        chk("misalign_forced_pc", first_pc, 32'h0000_4000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
